barcode_param_scanner: RTL and testbench

- Streaming side-tap that recovers the convolution parameters (kernel K, stride S, dilation D) from a Code 128-C barcode embedded in pixel LSBs.
- Snoops the same image stream the core writes into the image SRAM banks, generalised to LANES pixels per beat and any image size and barcode height.
- Reports one parameter set per frame, with a validity flag.
- The convolution control FSM reads the result to choose between the weight-load path and the invalid-parameter path.

---
 rtl/bcs_pkg.sv | 37 +++
 rtl/bcs_start_matcher.sv | 28 ++
 rtl/barcode_param_scanner.sv | 222 ++++++++++++++++++++++
 tb/tb_barcode_param_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcs_pkg.sv
// Shared constants, state encoding and symbol decode for the barcode parameter scanner.
// The bit patterns are the Code 128 START-C, STOP and code-set-C values 1..3.
package bcs_pkg;

  localparam int SEQ_W = 57;

  localparam logic [10:0] BCS_START = 11'b11010011100;
  localparam logic [12:0] BCS_STOP  = 13'b1100011101011;
  localparam logic [10:0] BCS_SYM1  = 11'b11001101100;
  localparam logic [10:0] BCS_SYM2  = 11'b11001100110;
  localparam logic [10:0] BCS_SYM3  = 11'b10010011000;

  localparam int F_START_HI = 56;
  localparam int F_START_LO = 46;
  localparam int F_K_HI     = 45;
  localparam int F_K_LO     = 35;
  localparam int F_S_HI     = 34;
  localparam int F_S_LO     = 24;
  localparam int F_D_HI     = 23;
  localparam int F_D_LO     = 13;
  localparam int F_STOP_HI  = 12;
  localparam int F_STOP_LO  = 0;

  typedef enum logic [1:0] {SEARCH, COLLECT, TRACK, LOCK} bcs_state_e;

  function automatic logic [1:0] bcs_sym_decode(input logic [10:0] code);
    logic [1:0] val;
    case (code)
      BCS_SYM1: val = 2'd1;
      BCS_SYM2: val = 2'd2;
      BCS_SYM3: val = 2'd3;
      default:  val = 2'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/bcs_start_matcher.sv
// Finds the earliest lane of a beat at which an 11-bit START pattern ends.
// i_win holds the 10 previous row bits above the LANES current bits (oldest at MSB).
module bcs_start_matcher
  import bcs_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [10+LANES-1:0] i_win,
  output logic                o_match,
  output logic [2:0]          o_lane
);

  logic [LANES-1:0] hit;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign hit[gi] = (i_win[LANES-1-gi +: 11] == BCS_START);
  end

  // Walk from the last lane down so the leftmost match wins.
  always_comb begin
    o_match = |hit;
    o_lane  = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (hit[l]) o_lane = 3'(l);
    end
  end

endmodule

// File: rtl/barcode_param_scanner.sv
// Side-tap on the image stream that locates a Code 128-C barcode in pixel LSBs and
// reports the kernel, stride and dilation it encodes once per frame.
module barcode_param_scanner
  import bcs_pkg::*;
#(
  parameter int         LANES    = 4,
  parameter int         IMG_W    = 64,
  parameter int         IMG_H    = 64,
  parameter int         BAR_H    = 10,
  parameter logic [2:0] KER_MASK = 3'b100
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sof,
  input  logic               i_valid,
  input  logic [8*LANES-1:0] i_data,
  output logic               o_res_valid,
  output logic               o_ok,
  output logic [1:0]         o_ker,
  output logic [1:0]         o_str,
  output logic [1:0]         o_dil
);

  localparam int BEATS = IMG_W * IMG_H / LANES;
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int BW    = $clog2(BEATS + 1);
  localparam int HW    = $clog2(BAR_H + 1);

  bcs_state_e       state_q, state_d;
  logic [CW-1:0]    col_q, col_d, anchor_q, anchor_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [HW-1:0]    hit_q, hit_d;
  logic             active_q, active_d;
  logic [9:0]       win_q, win_d;
  logic [SEQ_W-1:0] cap_q, cap_d, lat_q, lat_d;
  logic             res_valid_q, res_valid_d, ok_q, ok_d;
  logic [1:0]       ker_q, ker_d, str_q, str_d, dil_q, dil_d;

  logic [LANES-1:0]    bits_vec;
  logic [9:0]          win_cur;
  logic [10+LANES-1:0] full_win;
  logic                m_match;
  logic [2:0]          m_lane;
  logic                unused_data;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_bits
    assign bits_vec[gi] = i_data[8*gi];
  end
  assign unused_data = ^i_data;

  // The sliding window never carries bits across a row or frame boundary.
  assign win_cur  = (i_sof || col_q == '0) ? '0 : win_q;
  assign full_win = {win_cur, bits_vec};

  bcs_start_matcher #(.LANES(LANES)) u_matcher (
    .i_win   (full_win),
    .o_match (m_match),
    .o_lane  (m_lane)
  );

  function automatic logic seq_legal(input logic [SEQ_W-1:0] s);
    logic [1:0] k, sv, dv;
    k  = bcs_sym_decode(s[F_K_HI:F_K_LO]);
    sv = bcs_sym_decode(s[F_S_HI:F_S_LO]);
    dv = bcs_sym_decode(s[F_D_HI:F_D_LO]);
    return (s[F_START_HI:F_START_LO] == BCS_START) && (s[F_STOP_HI:F_STOP_LO] == BCS_STOP) &&
           (k != 2'd0) && KER_MASK[k - 2'd1] && (sv != 2'd0) && (dv != 2'd0);
  endfunction

  always_comb begin
    bcs_state_e          st;
    int                  col, pc, anchor, hit, beat, feed_from, skip_upto;
    logic [LANES-1:0]    fb;
    logic [10+LANES-1:0] fwin;

    state_d     = state_q;
    col_d       = col_q;
    anchor_d    = anchor_q;
    beat_d      = beat_q;
    hit_d       = hit_q;
    active_d    = active_q;
    win_d       = win_q;
    cap_d       = cap_q;
    lat_d       = lat_q;
    res_valid_d = res_valid_q;
    ok_d        = ok_q;
    ker_d       = ker_q;
    str_d       = str_q;
    dil_d       = dil_q;

    st        = state_q;
    col       = int'(col_q);
    anchor    = int'(anchor_q);
    beat      = int'(beat_q);
    hit       = int'(hit_q);
    feed_from = LANES;
    skip_upto = -1;
    pc        = 0;
    fb        = '0;
    fwin      = '0;

    if (i_valid && (i_sof || active_q)) begin
      if (i_sof) begin
        st          = SEARCH;
        col         = 0;
        beat        = 0;
        active_d    = 1'b1;
        res_valid_d = 1'b0;
        ok_d        = 1'b0;
        ker_d       = 2'd0;
        str_d       = 2'd0;
        dil_d       = 2'd0;
      end

      if (st == SEARCH) begin
        if (m_match && (col + int'(m_lane) - 10 >= 0) &&
            (col + int'(m_lane) - 10 + SEQ_W <= IMG_W)) begin
          st        = COLLECT;
          anchor    = col + int'(m_lane) - 10;
          skip_upto = col + int'(m_lane);
          cap_d     = {{(SEQ_W-11){1'b0}}, BCS_START};
        end else begin
          feed_from = 0;
        end
      end

      // Lanes are consumed left to right so a sequence can complete mid-beat.
      for (int l = 0; l < LANES; l++) begin
        pc = col + l;
        if ((st == COLLECT || st == TRACK) && pc > skip_upto &&
            pc >= anchor && pc <= anchor + SEQ_W - 1) begin
          cap_d = {cap_d[SEQ_W-2:0], bits_vec[LANES-1-l]};
          if (pc == anchor + SEQ_W - 1) begin
            if (st == COLLECT) begin
              if (cap_d[F_STOP_HI:F_STOP_LO] == BCS_STOP) begin
                lat_d = cap_d;
                hit   = 1;
                st    = TRACK;
              end else begin
                st        = SEARCH;
                feed_from = l + 1;
              end
            end else if (cap_d == lat_d) begin
              hit = hit + 1;
            end else if (cap_d[F_START_HI:F_START_LO] == BCS_START &&
                         cap_d[F_STOP_HI:F_STOP_LO] == BCS_STOP) begin
              lat_d = cap_d;
              hit   = 1;
            end else begin
              st = SEARCH;
            end
            if (st == TRACK && hit >= BAR_H) st = LOCK;
          end
        end
      end

      for (int l = 0; l < LANES; l++) begin
        if (l >= feed_from) fb[LANES-1-l] = bits_vec[LANES-1-l];
      end
      fwin  = {((feed_from == 0) ? win_cur : 10'd0), fb};
      win_d = fwin[9:0];

      col_d = (col + LANES >= IMG_W) ? '0 : CW'(col + LANES);
      beat  = beat + 1;
      if (beat == BEATS) begin
        beat        = 0;
        active_d    = 1'b0;
        res_valid_d = 1'b1;
        ok_d        = (st == LOCK) && seq_legal(lat_d);
        ker_d       = ok_d ? bcs_sym_decode(lat_d[F_K_HI:F_K_LO]) : 2'd0;
        str_d       = ok_d ? bcs_sym_decode(lat_d[F_S_HI:F_S_LO]) : 2'd0;
        dil_d       = ok_d ? bcs_sym_decode(lat_d[F_D_HI:F_D_LO]) : 2'd0;
      end

      beat_d   = BW'(beat);
      anchor_d = CW'(anchor);
      hit_d    = HW'(hit);
      state_d  = st;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= SEARCH;
      col_q       <= '0;
      anchor_q    <= '0;
      beat_q      <= '0;
      hit_q       <= '0;
      active_q    <= 1'b0;
      win_q       <= '0;
      cap_q       <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      ker_q       <= 2'd0;
      str_q       <= 2'd0;
      dil_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      anchor_q    <= anchor_d;
      beat_q      <= beat_d;
      hit_q       <= hit_d;
      active_q    <= active_d;
      win_q       <= win_d;
      cap_q       <= cap_d;
      lat_q       <= lat_d;
      res_valid_q <= res_valid_d;
      ok_q        <= ok_d;
      ker_q       <= ker_d;
      str_q       <= str_d;
      dil_q       <= dil_d;
    end
  end

  assign o_res_valid = res_valid_q;
  assign o_ok        = ok_q;
  assign o_ker       = ker_q;
  assign o_str       = str_q;
  assign o_dil       = dil_q;

endmodule

// File: tb/tb_barcode_param_scanner.sv
// Bench for barcode_param_scanner: four instances (LANES 4/4/1/8, two kernel masks) fed
// from a 64x64 LSB image; expected results are queued per frame and popped at frame end.
module tb_barcode_param_scanner;
  import bcs_pkg::*;

  typedef struct packed {
    logic       ok;
    logic [1:0] k;
    logic [1:0] s;
    logic [1:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sof_v, val_v, rv_v, ok_v;
  logic [63:0] dat_v [4];
  logic [1:0]  ker_v [4];
  logic [1:0]  str_v [4];
  logic [1:0]  dil_v [4];

  bit   img [64][64];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  barcode_param_scanner #(.LANES(4), .IMG_W(64), .IMG_H(64), .BAR_H(10), .KER_MASK(3'b100)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof_v[0]), .i_valid(val_v[0]), .i_data(dat_v[0][31:0]),
    .o_res_valid(rv_v[0]), .o_ok(ok_v[0]), .o_ker(ker_v[0]), .o_str(str_v[0]), .o_dil(dil_v[0]));

  barcode_param_scanner #(.LANES(4), .IMG_W(64), .IMG_H(64), .BAR_H(10), .KER_MASK(3'b110)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof_v[1]), .i_valid(val_v[1]), .i_data(dat_v[1][31:0]),
    .o_res_valid(rv_v[1]), .o_ok(ok_v[1]), .o_ker(ker_v[1]), .o_str(str_v[1]), .o_dil(dil_v[1]));

  barcode_param_scanner #(.LANES(1), .IMG_W(64), .IMG_H(64), .BAR_H(10), .KER_MASK(3'b100)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof_v[2]), .i_valid(val_v[2]), .i_data(dat_v[2][7:0]),
    .o_res_valid(rv_v[2]), .o_ok(ok_v[2]), .o_ker(ker_v[2]), .o_str(str_v[2]), .o_dil(dil_v[2]));

  barcode_param_scanner #(.LANES(8), .IMG_W(64), .IMG_H(64), .BAR_H(10), .KER_MASK(3'b100)) u_dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof_v[3]), .i_valid(val_v[3]), .i_data(dat_v[3]),
    .o_res_valid(rv_v[3]), .o_ok(ok_v[3]), .o_ker(ker_v[3]), .o_str(str_v[3]), .o_dil(dil_v[3]));

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int lanes_of(input int u);
    case (u)
      0, 1:    return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [10:0] sym(input int v);
    case (v)
      1:       return BCS_SYM1;
      2:       return BCS_SYM2;
      3:       return BCS_SYM3;
      default: return 11'b10101010101;
    endcase
  endfunction

  function automatic logic [56:0] mk_seq(input int k, input int s, input int d);
    return {BCS_START, sym(k), sym(s), sym(d), BCS_STOP};
  endfunction

  task automatic clear_img();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) img[r][c] = 1'b0;
  endtask

  task automatic put_bar(input int r0, input int nrows, input int col, input logic [56:0] seq);
    for (int r = r0; r < r0 + nrows; r++)
      for (int i = 0; i < 57; i++) img[r][col+i] = seq[56-i];
  endtask

  // One beat per call; the upper pixel bits are random so only the LSBs carry meaning.
  task automatic drive_beat(input int u, input bit sof, input int b);
    int          lanes, row, col;
    logic [63:0] w;
    lanes = lanes_of(u);
    if ($urandom_range(0, 31) == 0) @(posedge clk);
    @(negedge clk);
    row = (b * lanes) / 64;
    col = (b * lanes) % 64;
    w   = '0;
    for (int l = 0; l < lanes; l++) w[8*(lanes-1-l) +: 8] = {7'($urandom), img[row][col+l]};
    dat_v[u] = w;
    sof_v[u] = sof;
    val_v[u] = 1'b1;
    @(posedge clk);
    #1;
    sof_v[u] = 1'b0;
    val_v[u] = 1'b0;
  endtask

  task automatic finish_check(input int u);
    exp_t e;
    e = exp_q.pop_front();
    check_eq($sformatf("u%0d res_valid", u), int'(rv_v[u]), 1);
    check_eq($sformatf("u%0d ok", u), int'(ok_v[u]), int'(e.ok));
    check_eq($sformatf("u%0d ker", u), int'(ker_v[u]), int'(e.k));
    check_eq($sformatf("u%0d str", u), int'(str_v[u]), int'(e.s));
    check_eq($sformatf("u%0d dil", u), int'(dil_v[u]), int'(e.d));
    $display("frame u%0d: ok=%0d ker=%0d str=%0d dil=%0d (exp %0d %0d %0d %0d)", u,
             ok_v[u], ker_v[u], str_v[u], dil_v[u], e.ok, e.k, e.s, e.d);
  endtask

  task automatic run_frame(input int u, input bit eok, input int ek, input int es, input int ed);
    int   nb;
    exp_t e;
    nb   = 4096 / lanes_of(u);
    e.ok = eok;
    e.k  = 2'(ek);
    e.s  = 2'(es);
    e.d  = 2'(ed);
    exp_q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      drive_beat(u, b == 0, b);
      if (b == nb - 2) check_eq($sformatf("u%0d early_valid", u), int'(rv_v[u]), 0);
    end
    finish_check(u);
  endtask

  initial begin
    rst_n = 1'b1;
    sof_v = '0;
    val_v = '0;
    for (int u = 0; u < 4; u++) dat_v[u] = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check_eq($sformatf("u%0d rst_valid", u), int'(rv_v[u]), 0);
      check_eq($sformatf("u%0d rst_ok", u), int'(ok_v[u]), 0);
      check_eq($sformatf("u%0d rst_ker", u), int'(ker_v[u]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    clear_img(); put_bar(20, 10, 5, mk_seq(3, 1, 2));
    run_frame(0, 1, 3, 1, 2);

    clear_img(); put_bar(20, 9, 5, mk_seq(3, 1, 2));
    run_frame(0, 0, 0, 0, 0);

    clear_img(); put_bar(20, 10, 5, mk_seq(2, 1, 2));
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 1, 2, 1, 2);

    // Row 20 latches with a bad D symbol; row 21 differs but is framed, so it re-anchors.
    clear_img(); put_bar(20, 1, 5, mk_seq(3, 2, 0)); put_bar(21, 10, 5, mk_seq(3, 2, 3));
    run_frame(0, 1, 3, 2, 3);

    clear_img(); put_bar(10, 10, 0, mk_seq(3, 3, 1));
    run_frame(2, 1, 3, 3, 1);
    clear_img(); put_bar(40, 10, 7, mk_seq(3, 1, 3));
    run_frame(2, 1, 3, 1, 3);

    clear_img(); put_bar(0, 10, 0, mk_seq(3, 2, 1));
    run_frame(3, 1, 3, 2, 1);
    clear_img(); put_bar(53, 11, 7, mk_seq(3, 3, 3));
    run_frame(3, 1, 3, 3, 3);

    // New frame clears the held result on its first edge, then reset lands at beat 500.
    clear_img(); put_bar(20, 10, 5, mk_seq(3, 1, 2));
    drive_beat(0, 1'b1, 0);
    check_eq("sof_clears_valid", int'(rv_v[0]), 0);
    for (int b = 1; b < 500; b++) drive_beat(0, 1'b0, b);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", int'(rv_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 1100; b++) drive_beat(0, 1'b0, b % 1024);
    check_eq("no_sof_ignored", int'(rv_v[0]), 0);
    run_frame(0, 1, 3, 1, 2);

    // A frame that locks early is abandoned by a mid-frame sof onto an empty image.
    clear_img(); put_bar(0, 10, 5, mk_seq(3, 1, 2));
    drive_beat(0, 1'b1, 0);
    check_eq("sof_drop_valid", int'(rv_v[0]), 0);
    for (int b = 1; b < 300; b++) drive_beat(0, 1'b0, b);
    clear_img();
    run_frame(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
